// File: rtl/dec_pkg.sv
// Shared types and helpers for the pipelined 3-to-8 decoder.
// Holds the occupancy enum, default sizes and the one-hot decode.
package dec_pkg;

  typedef enum logic [1:0] {
    EMPTY   = 2'd0,
    PARTIAL = 2'd1,
    FULL    = 2'd2
  } occ_e;

  localparam int unsigned DEC_DEPTH = 2;
  localparam int unsigned DEC_CNT_W = 8;

  function automatic logic [7:0] dec_onehot(
    input logic [2:0] a
  );
    return 8'b1 << a;
  endfunction

endpackage

// File: rtl/dec_fifo.sv
// Small FIFO holding decoded words; pointers wrap at DEPTH-1.
// Ports: push_i/data_i write, pop_i read, head_o/occ_o state.
module dec_fifo
  import dec_pkg::*;
#(
  parameter int unsigned DEPTH = DEC_DEPTH,
  parameter int unsigned W     = 8
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       push_i,
  input  logic                       pop_i,
  input  logic [W-1:0]               data_i,
  output logic [W-1:0]               head_o,
  output logic [$clog2(DEPTH+1)-1:0] occ_o
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned OW = $clog2(DEPTH+1);

  logic [W-1:0]  mem_q [DEPTH];
  logic [W-1:0]  mem_d [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [OW-1:0] occ_q, occ_d;

  // Explicit wrap so non-power-of-two depths work.
  function automatic logic [PW-1:0] wrap_inc(
    input logic [PW-1:0] p
  );
    return (p == PW'(DEPTH-1)) ? '0 : p + PW'(1);
  endfunction

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    occ_d    = occ_q;
    if (push_i) begin
      mem_d[wr_ptr_q] = data_i;
      wr_ptr_d        = wrap_inc(wr_ptr_q);
    end
    if (pop_i) begin
      rd_ptr_d = wrap_inc(rd_ptr_q);
    end
    if (push_i && !pop_i) begin
      occ_d = occ_q + OW'(1);
    end else if (pop_i && !push_i) begin
      occ_d = occ_q - OW'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mem_q    <= '{default: '0};
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      occ_q    <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      occ_q    <= occ_d;
    end
  end

  assign head_o = mem_q[rd_ptr_q];
  assign occ_o  = occ_q;

endmodule

// File: rtl/decoder_3_to_8_pipe.sv
// Pipelined 3-to-8 decoder with valid/ready handshakes and a
// buffered output. Ports: valid_i/ready_o/a_i/en_i in, valid_o/
// ready_i/y_o out, count_o counts enabled decodes accepted.
module decoder_3_to_8_pipe
  import dec_pkg::*;
#(
  parameter int unsigned DEPTH = DEC_DEPTH,
  parameter int unsigned CNT_W = DEC_CNT_W
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             valid_i,
  output logic             ready_o,
  input  logic [2:0]       a_i,
  input  logic             en_i,
  output logic             valid_o,
  input  logic             ready_i,
  output logic [7:0]       y_o,
  output logic [CNT_W-1:0] count_o
);

  localparam int unsigned OW = $clog2(DEPTH+1);

  occ_e             state_q, state_d;
  logic             live_q, live_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             push, pop;
  logic [7:0]       word, head;
  logic [OW-1:0]    occ;

  // live_q holds ready_o low until the first edge out of reset.
  assign ready_o = live_q && (state_q != FULL);
  assign valid_o = (state_q != EMPTY);
  assign push    = valid_i && ready_o;
  assign pop     = valid_o && ready_i;
  assign word    = en_i ? dec_onehot(a_i) : 8'h00;
  assign y_o     = valid_o ? head : 8'h00;
  assign count_o = count_q;

  dec_fifo #(
    .DEPTH (DEPTH),
    .W     (8)
  ) u_fifo (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .push_i (push),
    .pop_i  (pop),
    .data_i (word),
    .head_o (head),
    .occ_o  (occ)
  );

  always_comb begin
    state_d = state_q;
    live_d  = 1'b1;
    count_d = count_q;
    if (push && en_i) begin
      count_d = count_q + CNT_W'(1);
    end
    unique case (state_q)
      EMPTY: begin
        if (push) state_d = PARTIAL;
      end
      PARTIAL: begin
        if (push && !pop && occ == OW'(DEPTH-1)) begin
          state_d = FULL;
        end else if (pop && !push && occ == OW'(1)) begin
          state_d = EMPTY;
        end
      end
      FULL: begin
        if (pop) state_d = PARTIAL;
      end
      default: state_d = EMPTY;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= EMPTY;
      live_q  <= 1'b0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      live_q  <= live_d;
      count_q <= count_d;
    end
  end

endmodule

// File: tb/tb_decoder_3_to_8_pipe.sv
// Self-checking bench for decoder_3_to_8_pipe.
// Directed table, corner sequences and a random scoreboard run.
module tb_decoder_3_to_8_pipe;

  localparam int DEPTH = 2;
  localparam int CNT_W = 8;

  logic             clk = 1'b0;
  logic             rst_ni;
  logic             valid_i;
  logic             ready_o;
  logic [2:0]       a_i;
  logic             en_i;
  logic             valid_o;
  logic             ready_i;
  logic [7:0]       y_o;
  logic [CNT_W-1:0] count_o;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [2:0] a;
    logic       en;
    logic [7:0] y;
  } vec_t;

  vec_t vecs [11];

  always #5 clk = ~clk;

  decoder_3_to_8_pipe #(
    .DEPTH (DEPTH),
    .CNT_W (CNT_W)
  ) dut (
    .clk_i   (clk),
    .rst_ni  (rst_ni),
    .valid_i (valid_i),
    .ready_o (ready_o),
    .a_i     (a_i),
    .en_i    (en_i),
    .valid_o (valid_o),
    .ready_i (ready_i),
    .y_o     (y_o),
    .count_o (count_o)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      if (errors <= 20)
        $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  logic [7:0] exp_cnt;
  logic [7:0] q [$];
  logic       exp_rdy;
  logic       do_pop;
  logic       do_push;
  int         sent;
  int         cyc;

  initial begin
    rst_ni  = 1'b0;
    valid_i = 1'b0;
    ready_i = 1'b0;
    a_i     = 3'd0;
    en_i    = 1'b0;

    vecs[0]  = '{3'd0, 1'b1, 8'h01};
    vecs[1]  = '{3'd1, 1'b1, 8'h02};
    vecs[2]  = '{3'd2, 1'b1, 8'h04};
    vecs[3]  = '{3'd3, 1'b1, 8'h08};
    vecs[4]  = '{3'd4, 1'b1, 8'h10};
    vecs[5]  = '{3'd5, 1'b1, 8'h20};
    vecs[6]  = '{3'd6, 1'b1, 8'h40};
    vecs[7]  = '{3'd7, 1'b1, 8'h80};
    vecs[8]  = '{3'd5, 1'b0, 8'h00};
    vecs[9]  = '{3'd7, 1'b0, 8'h00};
    vecs[10] = '{3'd0, 1'b1, 8'h01};

    // reset state
    #2;
    chk("rst_valid", valid_o, 0);
    chk("rst_y", y_o, 0);
    chk("rst_ready", ready_o, 0);
    chk("rst_count", count_o, 0);
    repeat (2) step();
    chk("rst_ready_held", ready_o, 0);
    rst_ni = 1'b1;
    step();
    chk("ready_after_rst", ready_o, 1);
    chk("valid_after_rst", valid_o, 0);
    exp_cnt = 8'd0;

    // table sweep with consumer always ready
    ready_i = 1'b1;
    for (int i = 0; i < 11; i++) begin
      valid_i = 1'b1;
      a_i     = vecs[i].a;
      en_i    = vecs[i].en;
      step();
      if (vecs[i].en) exp_cnt++;
      chk($sformatf("tbl_y%0d", i), y_o, vecs[i].y);
      chk($sformatf("tbl_v%0d", i), valid_o, 1);
      chk($sformatf("tbl_c%0d", i), count_o, exp_cnt);
      if (i == 7) chk("sweep_cnt8", count_o, 8);
    end
    valid_i = 1'b0;
    a_i     = 3'd5;
    en_i    = 1'b1;
    step();
    chk("drain_valid", valid_o, 0);
    chk("drain_y", y_o, 0);
    chk("idle_count", count_o, exp_cnt);

    // backpressure: fill, ignore third, drain
    ready_i = 1'b0;
    valid_i = 1'b1;
    a_i     = 3'd1;
    en_i    = 1'b1;
    step();
    chk("bp_y1", y_o, 8'h02);
    chk("bp_rdy1", ready_o, 1);
    a_i = 3'd2;
    step();
    exp_cnt = exp_cnt + 8'd2;
    chk("bp_full_rdy", ready_o, 0);
    chk("bp_stable", y_o, 8'h02);
    a_i = 3'd6;
    step();
    chk("bp_ign_rdy", ready_o, 0);
    chk("bp_ign_y", y_o, 8'h02);
    chk("bp_ign_cnt", count_o, exp_cnt);
    valid_i = 1'b0;
    ready_i = 1'b1;
    #1;
    chk("bp_no_comb", ready_o, 0);
    step();
    chk("bp_pop_y", y_o, 8'h04);
    chk("bp_pop_v", valid_o, 1);
    chk("bp_rdy_back", ready_o, 1);
    step();
    chk("bp_empty_v", valid_o, 0);
    chk("bp_empty_y", y_o, 0);

    // async reset while full
    ready_i = 1'b0;
    valid_i = 1'b1;
    a_i     = 3'd4;
    step();
    a_i = 3'd6;
    step();
    valid_i = 1'b0;
    chk("ar_full", ready_o, 0);
    #3 rst_ni = 1'b0;
    #1;
    chk("ar_valid", valid_o, 0);
    chk("ar_y", y_o, 0);
    chk("ar_ready", ready_o, 0);
    chk("ar_count", count_o, 0);
    #2 rst_ni = 1'b1;
    step();
    chk("ar_rdy_rel", ready_o, 1);
    chk("ar_flushed", valid_o, 0);
    exp_cnt = 8'd0;
    valid_i = 1'b1;
    ready_i = 1'b1;
    a_i     = 3'd3;
    en_i    = 1'b1;
    step();
    exp_cnt++;
    chk("ar_first_y", y_o, 8'h08);
    chk("ar_first_c", count_o, exp_cnt);

    // counter wrap: 255 more enabled pushes -> 256 total
    for (int i = 0; i < 255; i++) begin
      a_i = 3'(i);
      step();
      exp_cnt++;
      chk("wrap_cnt", count_o, exp_cnt);
    end
    chk("wrap_zero", count_o, 0);
    valid_i = 1'b0;
    step();

    // random stalls against a scoreboard
    sent = 0;
    cyc  = 0;
    q.delete();
    while ((sent < 1000 || q.size() > 0) && cyc < 20000) begin
      cyc++;
      valid_i = (sent < 1000) && ($urandom_range(0, 3) != 0);
      a_i     = 3'($urandom_range(0, 7));
      en_i    = ($urandom_range(0, 7) != 0);
      ready_i = ($urandom_range(0, 2) != 0);
      exp_rdy = (q.size() < DEPTH);
      chk("rnd_ready", ready_o, exp_rdy);
      chk("rnd_valid", valid_o, q.size() != 0);
      chk("rnd_y", y_o, (q.size() != 0) ? q[0] : 8'h00);
      chk("rnd_count", count_o, exp_cnt);
      do_pop  = (q.size() > 0) && ready_i;
      do_push = valid_i && exp_rdy;
      if (do_pop) void'(q.pop_front());
      if (do_push) begin
        q.push_back(en_i ? 8'(1 << a_i) : 8'h00);
        sent++;
        if (en_i) exp_cnt++;
      end
      step();
    end
    if (sent < 1000 || q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL rnd_timeout: sent %0d left %0d required 1000 and 0",
               sent, q.size());
    end
    chk("rnd_end_valid", valid_o, 0);
    chk("rnd_end_count", count_o, exp_cnt);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
